// File: rtl/ebi_read_responder_if.sv
// Bundle of the MCU EBI pad signals and the internal read port serviced by ebi_read_responder.
// The responder uses the slave view; whatever models the MCU and register space uses master.
interface ebi_read_responder_if;
  logic [15:0] EBI_AD_in;
  logic        EBI_ALE;
  logic        EBI_RE;
  logic        EBI_WE;
  logic [15:0] EBI_AD_out;
  logic        EBI_AD_oe;
  logic [15:0] rd_addr;
  logic        rd_req;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic        timeout_err;
  logic        late_err;

  modport slave (
    input  EBI_AD_in, EBI_ALE, EBI_RE, EBI_WE, rd_valid, rd_data,
    output EBI_AD_out, EBI_AD_oe, rd_addr, rd_req, timeout_err, late_err
  );

  modport master (
    output EBI_AD_in, EBI_ALE, EBI_RE, EBI_WE, rd_valid, rd_data,
    input  EBI_AD_out, EBI_AD_oe, rd_addr, rd_req, timeout_err, late_err
  );
endinterface

// File: rtl/ebi_read_responder.sv
// MCU EBI read responder: latches the address on ALE rise, prefetches a word over rd_req/rd_valid
// and drives it onto the shared AD bus while the MCU holds RE low.
//
// state   | meaning
// IDLE    | waiting for an address phase (synced ALE rising edge)
// FETCH   | rd_req high, waiting for rd_valid or the fetch timeout
// READY   | word held, waiting for RE low
// DRIVE   | word driven on AD until RE returns high
// WAITREL | bus released after ALE/WE contention, waiting for RE high
module ebi_read_responder #(
  parameter int          SYNC_STAGES = 2,
  parameter int          TIMEOUT     = 15,
  parameter logic [15:0] ERR_DATA    = 16'hDEAD
) (
  input logic                 clk,
  input logic                 reset,
  ebi_read_responder_if.slave bus
);
  localparam int            TW  = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO = TW'(TIMEOUT);

  typedef enum logic [2:0] {IDLE, FETCH, READY, DRIVE, WAITREL} state_t;

  logic [SYNC_STAGES-1:0] ale_sync_q, re_sync_q, we_sync_q;
  logic [15:0]            ad_sync_q [SYNC_STAGES];
  logic                   ale_prev_q;

  state_t        state_q;
  logic [15:0]   rd_addr_q;
  logic          rd_req_q;
  logic [TW-1:0] timer_q;
  logic [15:0]   data_q;
  logic [15:0]   ad_out_q;
  logic          oe_q;
  logic          timeout_err_q;
  logic          late_err_q;
  logic          late_seen_q;

  logic        ale_s, re_s, we_s;
  logic        ale_ahead, we_ahead;
  logic [15:0] ad_s;
  logic        ale_rise, abort;

  assign ale_s     = ale_sync_q[SYNC_STAGES-1];
  assign re_s      = re_sync_q[SYNC_STAGES-1];
  assign we_s      = we_sync_q[SYNC_STAGES-1];
  assign ad_s      = ad_sync_q[SYNC_STAGES-1];
  // Values the synced strobes take next cycle; lets the registered oe drop together with them.
  assign ale_ahead = ale_sync_q[SYNC_STAGES-2];
  assign we_ahead  = we_sync_q[SYNC_STAGES-2];
  assign ale_rise  = ale_s & ~ale_prev_q;
  assign abort     = ~ale_s | ~we_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ale_sync_q <= '1;
      re_sync_q  <= '1;
      we_sync_q  <= '1;
      ale_prev_q <= 1'b1;
      for (int i = 0; i < SYNC_STAGES; i++) ad_sync_q[i] <= '0;
    end else begin
      ale_sync_q   <= {ale_sync_q[SYNC_STAGES-2:0], bus.EBI_ALE};
      re_sync_q    <= {re_sync_q[SYNC_STAGES-2:0], bus.EBI_RE};
      we_sync_q    <= {we_sync_q[SYNC_STAGES-2:0], bus.EBI_WE};
      ale_prev_q   <= ale_s;
      ad_sync_q[0] <= bus.EBI_AD_in;
      for (int i = 1; i < SYNC_STAGES; i++) ad_sync_q[i] <= ad_sync_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      rd_addr_q     <= '0;
      rd_req_q      <= 1'b0;
      timer_q       <= '0;
      data_q        <= '0;
      ad_out_q      <= '0;
      oe_q          <= 1'b0;
      timeout_err_q <= 1'b0;
      late_err_q    <= 1'b0;
      late_seen_q   <= 1'b0;
    end else begin
      timeout_err_q <= 1'b0;
      late_err_q    <= 1'b0;
      oe_q          <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ale_rise) begin
            rd_addr_q   <= ad_s;
            rd_req_q    <= 1'b1;
            timer_q     <= '0;
            late_seen_q <= 1'b0;
            state_q     <= FETCH;
          end
        end
        FETCH: begin
          if (abort) begin
            rd_req_q <= 1'b0;
            state_q  <= IDLE;
          end else begin
            if (!re_s && !late_seen_q) begin
              late_err_q  <= 1'b1;
              late_seen_q <= 1'b1;
            end
            if (timer_q != TMO) timer_q <= timer_q + TW'(1);
            // rd_valid is checked first so it wins over a coincident timeout
            if (bus.rd_valid) begin
              data_q   <= bus.rd_data;
              rd_req_q <= 1'b0;
              state_q  <= re_s ? READY : DRIVE;
            end else if (timer_q == TMO) begin
              data_q        <= ERR_DATA;
              rd_req_q      <= 1'b0;
              timeout_err_q <= 1'b1;
              state_q       <= re_s ? READY : DRIVE;
            end
          end
        end
        READY: begin
          if (abort)      state_q <= IDLE;
          else if (!re_s) state_q <= DRIVE;
        end
        DRIVE: begin
          if (abort) begin
            state_q <= WAITREL;
          end else if (re_s) begin
            state_q <= IDLE;
          end else begin
            oe_q     <= ale_ahead & we_ahead;
            ad_out_q <= data_q;
          end
        end
        WAITREL: begin
          if (re_s) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.EBI_AD_out  = ad_out_q;
  assign bus.EBI_AD_oe   = oe_q;
  assign bus.rd_addr     = rd_addr_q;
  assign bus.rd_req      = rd_req_q;
  assign bus.timeout_err = timeout_err_q;
  assign bus.late_err    = late_err_q;
endmodule

// File: tb/tb_ebi_read_responder.sv
// Scoreboard bench for ebi_read_responder: MCU-side read cycles and an internal memory responder,
// with a monitor that checks every bus drive against words predicted from the fetch timing.
module tb_ebi_read_responder;
  localparam int          S   = 2;
  localparam int          TMO = 15;
  localparam logic [15:0] ERR = 16'hDEAD;

  logic clk = 1'b0;
  logic reset;

  ebi_read_responder_if bus();

  ebi_read_responder #(.SYNC_STAGES(S), .TIMEOUT(TMO), .ERR_DATA(ERR)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    int          n_tmo;
    int          n_late;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        cur_e;
  int          checks = 0;
  int          errors = 0;
  int          pushes = 0;
  int          drives = 0;
  logic [15:0] cur_addr = '0;
  logic [15:0] cur_data = '0;
  int          cur_delay = -1;
  bit          resp_busy = 1'b0;
  bit          req_seen = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Internal memory side: answers each new rd_req after cur_delay cycles (negative = never).
  // The pulse is issued even if the request was withdrawn meanwhile, exercising stale-valid paths.
  initial begin
    bus.rd_valid = 1'b0;
    bus.rd_data  = '0;
    forever begin
      @(negedge clk);
      if (!reset && bus.rd_req && !req_seen) begin
        chk("rd_addr", bus.rd_addr, cur_addr);
        if (cur_delay >= 0) begin
          resp_busy = 1'b1;
          repeat (cur_delay) @(negedge clk);
          bus.rd_valid = 1'b1;
          bus.rd_data  = cur_data;
          @(negedge clk);
          bus.rd_valid = 1'b0;
          bus.rd_data  = 16'($urandom);
          resp_busy    = 1'b0;
        end
      end
      req_seen = bus.rd_req;
    end
  end

  // Monitor: every oe rise consumes one expectation; the word must stay put while oe is high.
  initial begin
    bit oe_prev = 1'b0;
    int tcnt = 0;
    int lcnt = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        oe_prev = 1'b0;
        tcnt    = 0;
        lcnt    = 0;
      end else begin
        if (bus.timeout_err) tcnt++;
        if (bus.late_err) lcnt++;
        if (bus.EBI_AD_oe && !oe_prev) begin
          drives++;
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_drive: got oe=1 data %0h expected no drive", bus.EBI_AD_out);
          end else begin
            cur_e = sb_q.pop_front();
            chk("drive_data", bus.EBI_AD_out, cur_e.data);
            chk("timeout_pulses", tcnt, cur_e.n_tmo);
            chk("late_pulses", lcnt, cur_e.n_late);
          end
          tcnt = 0;
          lcnt = 0;
        end else if (bus.EBI_AD_oe) begin
          chk("drive_stable", bus.EBI_AD_out, cur_e.data);
        end
        oe_prev = bus.EBI_AD_oe;
      end
    end
  end

  task automatic addr_phase(input logic [15:0] addr, input logic [15:0] data, input int d,
                            input bit late);
    int w = 0;
    while (resp_busy && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (resp_busy) chk("resp_idle", resp_busy, 0);
    cur_addr  = addr;
    cur_data  = data;
    cur_delay = d;
    @(negedge clk);
    bus.EBI_ALE   = 1'b0;
    bus.EBI_AD_in = addr;
    repeat (2) @(negedge clk);
    bus.EBI_ALE = 1'b1;
    @(negedge clk);
    if (late) bus.EBI_RE = 1'b0;
    repeat (S + 1) @(negedge clk);
    bus.EBI_AD_in = 16'($urandom);
  endtask

  // One MCU read; expectation derived from when the word arrives relative to the timeout window.
  task automatic do_read(input logic [15:0] addr, input logic [15:0] data, input int d,
                         input bit late, input bit skip_re);
    exp_t e;
    bit   in_time = (d >= 0) && (d <= TMO);
    e.data   = in_time ? data : ERR;
    e.n_tmo  = in_time ? 0 : 1;
    e.n_late = late ? 1 : 0;
    if (!skip_re) begin
      sb_q.push_back(e);
      pushes++;
    end
    addr_phase(addr, data, d, late);
    if (skip_re) begin
      repeat (30) @(negedge clk);
      return;
    end
    if (!late) begin
      repeat ((in_time ? d : TMO + 1) + 8) @(negedge clk);
      bus.EBI_RE = 1'b0;
      repeat (S + 1) @(posedge clk);
      #1 chk("oe_latency_lo", bus.EBI_AD_oe, 0);
      @(posedge clk);
      #1 chk("oe_latency_hi", bus.EBI_AD_oe, 1);
      @(negedge clk);
      repeat ($urandom_range(2, 6)) @(negedge clk);
    end else begin
      repeat (S + TMO + 12) @(negedge clk);
    end
    bus.EBI_RE = 1'b1;
    repeat (S) @(posedge clk);
    #1 chk("oe_hold", bus.EBI_AD_oe, 1);
    @(posedge clk);
    #1 chk("oe_release", bus.EBI_AD_oe, 0);
    @(negedge clk);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    reset         = 1'b1;
    bus.EBI_AD_in = '0;
    bus.EBI_ALE   = 1'b1;
    bus.EBI_RE    = 1'b1;
    bus.EBI_WE    = 1'b1;
    #1;
    chk("rst_oe", bus.EBI_AD_oe, 0);
    chk("rst_ad_out", bus.EBI_AD_out, 0);
    chk("rst_rd_req", bus.rd_req, 0);
    chk("rst_rd_addr", bus.rd_addr, 0);
    chk("rst_timeout_err", bus.timeout_err, 0);
    chk("rst_late_err", bus.late_err, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    do_read(16'h0042, 16'h1234, 3, 1'b0, 1'b0);
    do_read(16'h0010, 16'h0BAD, -1, 1'b0, 1'b0);
    do_read(16'h0011, 16'hBEEF, 6, 1'b1, 1'b0);
    do_read(16'h0012, 16'h600D, TMO, 1'b0, 1'b0);
    do_read(16'h0013, 16'h0B0E, TMO + 1, 1'b0, 1'b0);

    // WE abort during the fetch: request withdrawn, later rd_valid must not reach the bus
    addr_phase(16'h0100, 16'hCAFE, 10, 1'b0);
    bus.EBI_WE = 1'b0;
    repeat (S + 1) @(posedge clk);
    #1 chk("we_abort_req", bus.rd_req, 0);
    @(negedge clk);
    bus.EBI_WE = 1'b1;
    repeat (25) @(negedge clk);
    chk("we_abort_req_after", bus.rd_req, 0);
    do_read(16'h0020, 16'h3C3C, 4, 1'b0, 1'b0);

    do_read(16'h0001, 16'hAAAA, 3, 1'b0, 1'b0);
    do_read(16'h0002, 16'h5555, 3, 1'b0, 1'b0);

    // Reset while driving, then a normal cycle
    sb_q.push_back('{data: 16'h7777, n_tmo: 0, n_late: 0});
    pushes++;
    addr_phase(16'h0300, 16'h7777, 2, 1'b0);
    repeat (S + 10) @(negedge clk);
    bus.EBI_RE = 1'b0;
    repeat (S + 2) @(posedge clk);
    #1 chk("pre_reset_oe", bus.EBI_AD_oe, 1);
    @(negedge clk);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("async_rst_oe", bus.EBI_AD_oe, 0);
    chk("async_rst_req", bus.rd_req, 0);
    chk("async_rst_ad_out", bus.EBI_AD_out, 0);
    @(negedge clk);
    @(negedge clk);
    bus.EBI_RE = 1'b1;
    reset      = 1'b0;
    repeat (3) @(negedge clk);
    do_read(16'h0301, 16'h8E8E, 5, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      int          r    = $urandom_range(0, 9);
      int          d;
      bit          late = ($urandom_range(0, 4) == 0);
      bit          skip;
      logic [15:0] a    = 16'($urandom);
      logic [15:0] w    = 16'($urandom);
      if (r == 0)      d = -1;
      else if (r == 1) d = TMO;
      else if (r == 2) d = TMO + 1;
      else             d = $urandom_range(0, 12);
      if (late && d >= 0 && d < 6) d = 6;
      skip = !late && d >= 0 && d <= 12 && ($urandom_range(0, 6) == 0);
      do_read(a, w, d, late, skip);
    end

    repeat (10) @(negedge clk);
    chk("sb_empty", sb_q.size(), 0);
    chk("drive_count", drives, pushes);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got time limit reached expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
